// File: rtl/rns_reverse_converter_pipe.sv
// RNS {2^N-1, 2^N+1, 2^2N+1, 2^(2N+P)} to binary converter, 4-stage valid/ready pipeline.
// Y = (X - r4) / 2^(2N+P) is rebuilt modulo 2^4N-1 from rotated/complemented residue fields.
module rns_reverse_converter_pipe #(
  parameter int N     = 20,
  parameter int P     = 7,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_r1,
  input  logic [N:0]         in_r2,
  input  logic [2*N:0]       in_r3,
  input  logic [2*N+P-1:0]   in_r4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6*N+P:0]     out_x,
  output logic               out_err,
  output logic [CNT_W-1:0]   conv_cnt,
  output logic [CNT_W-1:0]   err_cnt
);
  localparam int W      = 4*N;
  localparam int R4W    = 2*N+P;
  localparam int STAGES = 4;

  typedef logic [W-1:0] word_t;
  typedef struct packed { word_t s; word_t c; } sc_t;

  typedef struct packed {
    logic [N-1:0]   r1;
    logic [N:0]     r2;
    logic [2*N:0]   r3;
    logic [R4W-1:0] r4;
    logic           err;
  } s1_t;

  typedef struct packed {
    logic [4:0][W-1:0] ops;
    logic [R4W-1:0]    r4;
    logic              err;
  } s2_t;

  typedef struct packed {
    word_t          sum;
    word_t          cry;
    logic [R4W-1:0] r4;
    logic           err;
  } s3_t;

  // Multiplying by 2^s modulo 2^W-1 is a left rotation.
  function automatic word_t rotl(input word_t x, input int s);
    return (x << s) | (x >> (W - s));
  endfunction

  function automatic word_t eac_add(input word_t a, input word_t b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
  endfunction

  function automatic sc_t csa(input word_t a, input word_t b, input word_t c);
    sc_t o;
    o.s = a ^ b ^ c;
    o.c = rotl((a & b) | (a & c) | (b & c), 1);
    return o;
  endfunction

  localparam word_t M2      = {2{{N{1'b0}}, {N{1'b1}}}};
  localparam word_t M3      = {{(2*N){1'b0}}, {(2*N){1'b1}}};
  localparam word_t ONES_LO = ~({W{1'b1}} << (N+2));

  // Correction: cancels the constants carried by the complemented fields of
  // R2f/R3f/R4f; r2 = 2^N and r3 = 2^2N (low halves zero) fold in as an extra M2 / M3 term.
  function automatic word_t kword(input logic b2, input logic b3);
    word_t t2, t3;
    t2 = b2 ? rotl(M2, 1) : M2;
    t3 = b3 ? rotl(M3, 3*N+2) : rotl(M3, 3*N+1);
    return eac_add(eac_add(~t2, ~t3), ONES_LO);
  endfunction

  localparam word_t K00 = kword(1'b0, 1'b0);
  localparam word_t K01 = kword(1'b0, 1'b1);
  localparam word_t K10 = kword(1'b1, 1'b0);
  localparam word_t K11 = kword(1'b1, 1'b1);

  logic [STAGES:1] r_vld_pipe;
  logic            w_adv;
  s1_t             r_s1;
  s2_t             r_s2;
  s3_t             r_s3;

  assign w_adv     = !r_vld_pipe[STAGES] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst)        r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
  end

  // S1: latch and range check
  always_ff @(posedge clk) begin
    if (w_adv && in_valid) begin
      r_s1.r1  <= in_r1;
      r_s1.r2  <= in_r2;
      r_s1.r3  <= in_r3;
      r_s1.r4  <= in_r4;
      r_s1.err <= (in_r2[N] && |in_r2[N-1:0]) || (in_r3[2*N] && |in_r3[2*N-1:0]);
    end
  end

  // S2: operand build
  logic [N-1:0]      w_r2l;
  logic [2*N-1:0]    w_r3l;
  word_t             w_r4x, w_k;
  logic [4:0][W-1:0] w_ops;

  assign w_r2l = r_s1.r2[N-1:0];
  assign w_r3l = r_s1.r3[2*N-1:0];
  assign w_r4x = word_t'(r_s1.r4);

  always_comb begin
    w_k = K00;
    case ({r_s1.r2[N], r_s1.r3[2*N]})
      2'b01:   w_k = K01;
      2'b10:   w_k = K10;
      2'b11:   w_k = K11;
      default: w_k = K00;
    endcase
  end

  assign w_ops[0] = {4{r_s1.r1}};
  assign w_ops[1] = {w_r2l, ~w_r2l, w_r2l, ~w_r2l};
  assign w_ops[2] = rotl({~w_r3l, w_r3l}, N+1);
  assign w_ops[3] = ~((w_r4x << (N+2)) | ONES_LO);
  assign w_ops[4] = w_k;

  always_ff @(posedge clk) begin
    if (w_adv && r_vld_pipe[1]) begin
      r_s2.ops <= w_ops;
      r_s2.r4  <= r_s1.r4;
      r_s2.err <= r_s1.err;
    end
  end

  // S3: 5:2 end-around carry-save reduction
  sc_t w_l1, w_l2, w_l3;
  assign w_l1 = csa(r_s2.ops[0], r_s2.ops[1], r_s2.ops[2]);
  assign w_l2 = csa(r_s2.ops[3], r_s2.ops[4], w_l1.s);
  assign w_l3 = csa(w_l1.c, w_l2.c, w_l2.s);

  always_ff @(posedge clk) begin
    if (w_adv && r_vld_pipe[2]) begin
      r_s3.sum <= w_l3.s;
      r_s3.cry <= w_l3.c;
      r_s3.r4  <= r_s2.r4;
      r_s3.err <= r_s2.err;
    end
  end

  // S4: final modular add, undo the 2^(N+2) prescale, append r4
  word_t w_fin, w_res, w_y;
  assign w_fin = eac_add(r_s3.sum, r_s3.cry);
  assign w_res = (&w_fin) ? '0 : w_fin;
  assign w_y   = rotl(w_res, N-P-2);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_x   <= '0;
      out_err <= 1'b0;
    end else if (w_adv && r_vld_pipe[3]) begin
      out_x   <= r_s3.err ? '0 : {1'b0, w_y, r_s3.r4};
      out_err <= r_s3.err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (in_valid && w_adv && !(&conv_cnt))
        conv_cnt <= conv_cnt + CNT_W'(1);
      if (out_valid && out_ready && out_err && !(&err_cnt))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rns_reverse_converter_pipe.sv
// Directed bench for rns_reverse_converter_pipe at N=4, P=1 (moduli 15, 17, 257, 512).
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_rns_reverse_converter_pipe;
  localparam int N = 4;
  localparam int P = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]    in_r1;
  logic [4:0]    in_r2;
  logic [8:0]    in_r3;
  logic [8:0]    in_r4;
  logic [25:0]   out_x;
  logic [31:0]   conv_cnt, err_cnt;
  logic          in_ready2, out_valid2, out_err2;
  logic [25:0]   out_x2;
  logic [1:0]    conv_cnt2, err_cnt2;

  int checks, failures;
  int exp_conv, exp_err;

  always #5 clk = ~clk;

  rns_reverse_converter_pipe #(.N(N), .P(P), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r1(in_r1), .in_r2(in_r2), .in_r3(in_r3), .in_r4(in_r4),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_err(out_err),
    .conv_cnt(conv_cnt), .err_cnt(err_cnt)
  );

  rns_reverse_converter_pipe #(.N(N), .P(P), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_r1(in_r1), .in_r2(in_r2), .in_r3(in_r3), .in_r4(in_r4),
    .out_valid(out_valid2), .out_ready(out_ready), .out_x(out_x2), .out_err(out_err2),
    .conv_cnt(conv_cnt2), .err_cnt(err_cnt2)
  );

  // Directed tuples with hand-computed X (0 for out-of-range tuples)
  int V1[15] = '{10, 14, 15, 0, 1, 1, 2, 6, 0, 15, 3, 0, 0, 5, 0};
  int V2[15] = '{14, 16, 0, 17, 16, 1, 2, 2, 15, 15, 16, 0, 0, 31, 0};
  int V3[15] = '{229, 256, 0, 0, 16, 256, 255, 96, 133, 133, 256, 257, 511, 0, 0};
  int V4[15] = '{488, 511, 0, 0, 16, 256, 0, 64, 384, 384, 272, 0, 0, 3, 0};
  int VX[15] = '{1000, 33553919, 0, 0, 16, 256, 512, 123456, 30000000, 30000000, 4368, 0, 0, 0, 0};
  int VE[15] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};

  int S1[6] = '{10, 1, 1, 2, 6, 3};
  int S2[6] = '{14, 16, 1, 2, 2, 16};
  int S3[6] = '{229, 16, 256, 255, 96, 256};
  int S4[6] = '{488, 16, 256, 0, 64, 272};
  int SX[6] = '{1000, 16, 256, 512, 123456, 4368};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int c, input int d, input logic v);
    in_r1 = 4'(a); in_r2 = 5'(b); in_r3 = 9'(c); in_r4 = 9'(d); in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
    checks++; if (out_x !== 26'd0) begin failures++; $display("FAIL reset_out_x got=%0d exp=0", out_x); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0d exp=0", out_err); end
    checks++; if (conv_cnt !== 32'd0) begin failures++; $display("FAIL reset_conv_cnt got=%0d exp=0", conv_cnt); end
    checks++; if (err_cnt !== 32'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
    out_ready = 1'b1;
    exp_conv = 0; exp_err = 0;
  endtask

  task automatic test_basic();
    logic ev;
    int   ex;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      drive(0, 0, 0, 0, 1'b1);
      else if (c == 1) drive(1, 1, 1, 1, 1'b1);
      else             drive(0, 0, 0, 0, 1'b0);
      #1;
      ev = (c == 4) || (c == 5);
      ex = (c == 5) ? 1 : 0;
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL basic_valid c=%0d got=%0d exp=%0d", c, out_valid, ev); end
      if (ev) begin
        checks++; if (out_x !== 26'(ex)) begin failures++; $display("FAIL basic_x c=%0d got=%0d exp=%0d", c, out_x, ex); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL basic_err c=%0d got=%0d exp=0", c, out_err); end
      end
      tick();
    end
    exp_conv += 2;
  endtask

  task automatic test_vectors();
    logic ev;
    int   i;
    for (int c = 0; c <= 19; c++) begin
      if (c < 15) drive(V1[c], V2[c], V3[c], V4[c], 1'b1);
      else        drive(0, 0, 0, 0, 1'b0);
      #1;
      i  = c - 4;
      ev = (c >= 4) && (i < 15);
      checks++; if (out_valid !== ev || out_valid2 !== ev) begin failures++; $display("FAIL vec_valid c=%0d got=%0d exp=%0d", c, out_valid, ev); end
      if (ev) begin
        checks++; if (out_x !== 26'(VX[i])) begin failures++; $display("FAIL vec_x idx=%0d got=%0d exp=%0d", i, out_x, VX[i]); end
        checks++; if (out_err !== VE[i][0]) begin failures++; $display("FAIL vec_err idx=%0d got=%0d exp=%0d", i, out_err, VE[i]); end
        checks++; if (out_x2 !== 26'(VX[i]) || out_err2 !== VE[i][0]) begin failures++; $display("FAIL vec_x_sat_inst idx=%0d got=%0d exp=%0d", i, out_x2, VX[i]); end
      end
      tick();
    end
    exp_conv += 15; exp_err += 4;
    checks++; if (conv_cnt !== 32'(exp_conv)) begin failures++; $display("FAIL vec_conv_cnt got=%0d exp=%0d", conv_cnt, exp_conv); end
    checks++; if (err_cnt !== 32'(exp_err)) begin failures++; $display("FAIL vec_err_cnt got=%0d exp=%0d", err_cnt, exp_err); end
    checks++; if (conv_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_conv_cnt got=%0d exp=3", conv_cnt2); end
    checks++; if (err_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_err_cnt got=%0d exp=3", err_cnt2); end
  endtask

  task automatic test_stall();
    int   eo[14] = '{-1, -1, -1, -1, 0, 0, 0, 0, 1, 2, 3, 4, 5, -1};
    int   idx;
    logic rdy;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      rdy = !(c >= 4 && c <= 6);
      out_ready = rdy;
      if (idx < 6) drive(S1[idx], S2[idx], S3[idx], S4[idx], 1'b1);
      else         drive(0, 0, 0, 0, 1'b0);
      #1;
      checks++; if (in_ready !== rdy) begin failures++; $display("FAIL stall_in_ready c=%0d got=%0d exp=%0d", c, in_ready, rdy); end
      checks++; if (out_valid !== (eo[c] >= 0)) begin failures++; $display("FAIL stall_valid c=%0d got=%0d exp=%0d", c, out_valid, eo[c] >= 0); end
      if (eo[c] >= 0) begin
        checks++; if (out_x !== 26'(SX[eo[c]])) begin failures++; $display("FAIL stall_x c=%0d got=%0d exp=%0d", c, out_x, SX[eo[c]]); end
      end
      if (idx < 6 && rdy) idx++;
      tick();
    end
    out_ready = 1'b1;
    exp_conv += 6;
    checks++; if (conv_cnt !== 32'(exp_conv)) begin failures++; $display("FAIL stall_conv_cnt got=%0d exp=%0d", conv_cnt, exp_conv); end
    checks++; if (err_cnt !== 32'(exp_err)) begin failures++; $display("FAIL stall_err_cnt got=%0d exp=%0d", err_cnt, exp_err); end
  endtask

  task automatic test_reset_flush();
    drive(0, 0, 0, 0, 1'b1); tick();
    drive(1, 1, 1, 1, 1'b1); tick();
    drive(10, 14, 229, 488, 1'b1); tick();
    drive(0, 0, 0, 0, 1'b0);
    rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    exp_conv = 0; exp_err = 0;
    checks++; if (conv_cnt !== 32'd0 || conv_cnt2 !== 2'd0) begin failures++; $display("FAIL flush_conv_cnt got=%0d exp=0", conv_cnt); end
    checks++; if (err_cnt !== 32'd0 || err_cnt2 !== 2'd0) begin failures++; $display("FAIL flush_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0d exp=1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_emit c=%0d got=%0d exp=0", c, out_valid); end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(10, 14, 229, 488, 1'b1);
      else        drive(0, 0, 0, 0, 1'b0);
      #1;
      checks++; if (out_valid !== (c == 4)) begin failures++; $display("FAIL flush_valid c=%0d got=%0d exp=%0d", c, out_valid, c == 4); end
      if (c == 4) begin
        checks++; if (out_x !== 26'd1000) begin failures++; $display("FAIL flush_x got=%0d exp=1000", out_x); end
      end
      tick();
    end
    exp_conv = 1;
    checks++; if (conv_cnt !== 32'(exp_conv)) begin failures++; $display("FAIL flush_conv_after got=%0d exp=%0d", conv_cnt, exp_conv); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; out_ready = 1'b1;
    drive(0, 0, 0, 0, 1'b0);
    test_reset();
    test_basic();
    test_vectors();
    test_stall();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rns_reverse_converter_pipe.md
Name: rns_reverse_converter_pipe

Overview:
Pipelined, handshaked reverse (RNS-to-binary) converter for the four-moduli set {2^n-1, 2^n+1, 2^(2n)+1, 2^(2n+p)}. It is the clocked, parametrised successor of the combinational converter.
- Accepts one residue tuple per cycle and returns the unique binary X in [0, M), M = (2^(4n)-1)*2^(2n+p), after a fixed 4-stage latency.
- Adds valid/ready flow control, residue range checking with an error flag, and saturating status counters.
- Sits between the RNS arithmetic channels and the binary output datapath.

Parameters:
N, 20, base width n; legal range n >= 4.
P, 7, extra power on the fourth modulus; legal range 0 <= P <= N-2.
CNT_W, 32, width of the status counters.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  input tuple valid.
in_ready  out  1  converter can accept the tuple this cycle.
in_r1  in  N  residue mod 2^N-1.
in_r2  in  N+1  residue mod 2^N+1.
in_r3  in  2N+1  residue mod 2^(2N)+1.
in_r4  in  2N+P  residue mod 2^(2N+P).
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_x  out  6N+P+1  converted value X.
out_err  out  1  tuple was out of range; out_x forced to 0.
conv_cnt  out  CNT_W  accepted tuples, saturating.
err_cnt  out  CNT_W  tuples flagged out_err, saturating.

Behaviour:
- Reset (rst=1 at a clock edge) produces: all stage valid bits 0, out_valid=0, out_x=0, out_err=0, conv_cnt=0, err_cnt=0.
  - In-flight tuples are discarded and never emitted.
  - in_ready reads 1 in the first cycle after reset is released.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - out_valid, out_x and out_err stay stable while out_valid=1 and out_ready=0.
  - in_valid is registered and carries no combinational path to out_*.
- Pipeline: 4 stages, global advance enable adv = !out_valid || out_ready.
  - in_ready = adv.
  - Bubbles advance like data; no bubble collapsing is required.
  - An accepted tuple appears on out_* exactly 4 cycles later when adv stays 1.
  - Each cycle with adv=0 adds one cycle of latency.
  - Accept and emit in the same cycle is legal; throughput is 1 per cycle.
  - Output order equals input order.
- S1 (register + check):
  - Latch the residues.
  - err = (in_r2 > 2^N) || (in_r3 > 2^(2N)).
  - in_r1 = 2^N-1 is accepted as the alternate encoding of 0.
  - in_r4 is always valid.
- S2 (operand build), all values modulo 2^(4N)-1, 4N bits wide:
  - R1f: in_r1 replicated 4 times.
  - R2f: {r2l, ~r2l, r2l, ~r2l} with r2l = r2[N-1:0].
  - R3f: {~r3l, r3l} rotated left by N+1, with r3l = r3[2N-1:0].
  - R4f: {(N-P-2) ones, ~r4, (N+2) zeros}.
  - Correction word k is built from r2[N], r2[N-1], r3[2N], r3[2N-1] (equation 23).
- S3 (reduction): carry-save tree over the 5 operands with end-around carry, modulo 2^(4N)-1; registered sum and carry vectors.
- S4 (final):
  - End-around-carry add; an all-ones result maps to 0.
  - Y = result rotated left by N-P-2.
  - out_x = {Y, r4}, i.e. Y*2^(2N+P) + r4.
  - If err, out_x = 0 and out_err = 1.
- Arithmetic: no operator-based % or *; all modular reductions use end-around carry or rotation. The result must equal the CRT value for every legal tuple.
- Counters:
  - conv_cnt increments on each input handshake.
  - err_cnt increments on each output handshake with out_err=1.
  - Both hold at 2^CNT_W-1 (no wrap).
  - Both are cleared only by rst.

Test Plan:
(All tests at N=4, P=1: moduli 15, 17, 257, 512; M = 33553920; out_x is 26 bits.)
1. Residues (0,0,0,0) -> out_x=0 at cycle 4. Residues (1,1,1,1) -> out_x=1 at cycle 5 (back-to-back), out_err=0.
2. X=1000: residues (10,14,229,488) -> out_x=1000. X=M-1: residues (14,16,256,511) -> out_x=33553919.
3. r1=15 with others from X=0 (0,0,0) -> out_x=0. r2=17 -> out_err=1, out_x=0, err_cnt=1.
4. Stream 6 tuples back-to-back with out_ready=0 for 3 cycles starting at cycle 4 -> in_ready drops, out_x held stable, all 6 results delivered in order, conv_cnt=6.
5. Assert rst with 3 tuples in flight -> no out_valid afterwards, counters 0, next tuple (10,14,229,488) returns 1000 after 4 cycles.
6. Randomised 10^4 legal tuples plus a golden CRT model at N=4,P=1 and N=20,P=7 -> zero mismatches at full throughput with random out_ready.
